fp_alu_seq: RTL and testbench
=============================

// Module: fp_alu_seq
// PURPOSE
//   Multi-cycle, parametrised IEEE-754-style floating-point ALU: add, subtract, multiply.
//   Successor to the single-precision combinational add/mul ALU; generalised exponent/mantissa widths.
//   Operand and result paths use valid/ready handshakes; one operation in flight.
//   Multiply is an iterative shift-add; sits between the operand register file and the writeback stage.
// PARAMETERS
//   EXP_W   8    exponent field width (bias = 2**(EXP_W-1)-1)
//   MAN_W   23   stored mantissa width (hidden 1 implied)
//   W       1+EXP_W+MAN_W  word width (localparam, not overridable)
// PORTS
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    operands/op valid
//   in_ready   out  1    block can accept (high only in IDLE)
//   op         in   2    00 add, 01 sub (A-B), 10 mul, 11 reserved (treated as add)
//   a, b       in   W    operands {sign, exp, man}
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer accepts result
//   result     out  W    result word
//   overflow   out  1    result exponent saturated to all-ones (result = signed infinity)
//   zero       out  1    result is +0 (exact zero, or underflow flushed to zero)
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, result=0, overflow=0, zero=0; aborts any op in flight.
//   FSM: IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE (add/sub)
//        IDLE -> MULT (MAN_W+1 cycles) -> NORM -> ROUND -> DONE (mul); DONE -> IDLE on out_ready.
//   Accept on in_valid & in_ready edge; operands and op are registered; later input changes are ignored.
//   Latency from accept edge to out_valid high: add/sub 4 cycles, mul MAN_W+3 cycles (26 at default).
//   out_valid, result and flags hold stable in DONE until out_ready=1.
//   The release edge returns to IDLE; in_ready rises the next cycle (no accept on the release edge).
//   Subnormal input (exp=0) is treated as zero. Input with exp all-ones is treated as infinity:
//     result is signed infinity with overflow=1. Inf-Inf and Inf*0 give +0 with zero=1.
//   Sub: B sign inverted at accept; datapath then identical to add.
//   ALIGN: the smaller-exponent mantissa is shifted right by the exponent difference.
//     Shifts >= MAN_W+3 yield 0. Guard and round bits are kept; all bits below them OR into sticky.
//   ADDSUB: equal signs add (MAN_W+2-bit sum incl. carry). Unequal signs subtract smaller from larger magnitude;
//     result takes the larger operand's sign. Equal magnitudes give +0.
//   MULT: (MAN_W+1)x(MAN_W+1) shift-add, one partial product per cycle, 2*MAN_W+2-bit accumulator;
//     exp = ea+eb-bias, computed in EXP_W+2 signed bits.
//   NORM: single-cycle leading-one detect. Left shift lowers exp, carry/top-bit right shift raises it by 1.
//   ROUND: see CONFIGURATION; a mantissa carry-out from rounding increments exp.
//   Final exp >= 2**EXP_W-1 -> {sign, all-ones, 0}, overflow=1.
//   Final exp <= 0 -> result 0, zero=1 (flush; sign forced 0).
//   Either operand exactly zero (add/sub): result = the other operand with sign as applied; 0 +/- 0 = +0.
// CONFIGURATION
//   FP_ALU_RNE_EN defined: ROUND applies round-to-nearest-even using guard/round/sticky; 1 extra adder.
//   Undefined: ROUND truncates (guard/round/sticky discarded). The ROUND state still costs
//     1 cycle, so latency is identical in both builds.
// TESTING
//   1 add 0x3F800000+0x3F800000 -> 0x40000000 after 4 cycles, overflow=0, zero=0.
//   2 mul 0x3FC00000*0x40000000 -> 0x40400000 after 26 cycles; in_ready=0 throughout.
//   3 sub 0x40490FDB-0x40490FDB -> 0x00000000, zero=1; mul 0x7F7FFFFF*0x40000000 -> 0x7F800000, overflow=1.
//   4 add 0x3F800001+0x33800000 -> 0x3F800002 with FP_ALU_RNE_EN, 0x3F800001 without.
//   5 out_ready low 10 cycles in DONE -> result/out_valid stable, in_ready=0; release -> in_ready=1 next cycle.
//   6 rst pulse mid-MULT (cycle 12) -> immediate IDLE, out_valid=0; next op 0x40000000*0x40000000 -> 0x40800000.

Source files
------------

// File: rtl/fp_alu_seq.sv
// Multi-cycle FP add/sub/mul, valid/ready on both sides, one op in flight.
// Define FP_ALU_RNE_EN for round-to-nearest-even; otherwise ROUND truncates.

module fp_alu_seq #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         overflow,
   output logic         zero
);

   localparam int XW = EXP_W + 2;
   localparam int MW = MAN_W + 1;
   localparam int GW = MAN_W + 4;
   localparam int SW = MAN_W + 5;
   localparam int PW = 2 * MAN_W + 2;
   localparam int HW = MAN_W + 3;
   localparam int CW = $clog2(MAN_W + 2);
   localparam int LW = $clog2(GW + 1);

   localparam logic signed [XW-1:0] X_BIAS = XW'(2**(EXP_W-1) - 1);
   localparam logic signed [XW-1:0] X_EMAX = XW'(2**EXP_W - 1);
   localparam logic signed [XW-1:0] X_ONE  = XW'(1);
   localparam logic signed [XW-1:0] X_ZERO = XW'(0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ALIGN  = 3'd1;
   localparam logic [2:0] S_ADDSUB = 3'd2;
   localparam logic [2:0] S_MULT   = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_ROUND  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   logic [2:0]              r_state;
   logic                    r_mul;
   logic                    r_sa, r_sb;
   logic [EXP_W-1:0]        r_ea, r_eb;
   logic [MAN_W-1:0]        r_fa, r_fb;
   logic [MW-1:0]           r_ma, r_mb;
   logic                    r_za, r_zb, r_ia, r_ib;
   logic [GW-1:0]           r_big_m, r_sml_m;
   logic                    r_sub, r_rs;
   logic signed [XW-1:0]    r_re;
   logic [SW-1:0]           r_sum;
   logic [PW-1:0]           r_acc;
   logic [CW-1:0]           r_cnt;
   logic [GW-1:0]           r_nm;
   logic [W-1:0]            r_res;
   logic                    r_ov, r_zf;

   logic [EXP_W-1:0]        w_ea, w_eb;
   logic                    w_za, w_zb;
   assign w_ea = a[W-2:MAN_W];
   assign w_eb = b[W-2:MAN_W];
   assign w_za = (w_ea == '0);
   assign w_zb = (w_eb == '0);

   // Alignment: larger magnitude is "big", so subtraction never goes negative
   logic                    w_a_big, w_far;
   logic [EXP_W-1:0]        w_d;
   logic [MW-1:0]           w_bm, w_sm;
   logic [2*HW-1:0]         w_wide, w_shr;
   logic [GW-1:0]           w_sml_x;
   assign w_a_big = (r_ea > r_eb) || ((r_ea == r_eb) && (r_ma >= r_mb));
   assign w_d     = w_a_big ? r_ea - r_eb : r_eb - r_ea;
   assign w_bm    = w_a_big ? r_ma : r_mb;
   assign w_sm    = w_a_big ? r_mb : r_ma;
   assign w_far   = (32'(w_d) >= HW);
   assign w_wide  = {w_sm, 2'b00, {HW{1'b0}}};
   assign w_shr   = w_wide >> w_d;
   assign w_sml_x = w_far ? '0 : {w_shr[2*HW-1:HW], |w_shr[HW-1:0]};

   logic [PW-1:0]           w_pp, w_acc;
   logic [SW-1:0]           w_pk;
   assign w_pp  = r_mb[r_cnt] ? (PW'(r_ma) << r_cnt) : '0;
   assign w_acc = r_acc + w_pp;
   assign w_pk  = {w_acc[PW-1:MAN_W-2], |w_acc[MAN_W-3:0]};

   logic [LW-1:0]           w_lsh;
   logic                    w_hit;
   always_comb begin
      w_lsh = '0;
      w_hit = 1'b0;
      for (int i = GW - 1; i >= 0; i--) begin
         if (!w_hit && r_sum[i]) begin
            w_hit = 1'b1;
            w_lsh = LW'(GW - 1 - i);
         end
      end
   end

   logic [MAN_W-1:0]        w_frac;
   logic [MAN_W:0]          w_rf;
   logic signed [XW-1:0]    w_fe;
   assign w_frac = r_nm[GW-2:3];
`ifdef FP_ALU_RNE_EN
   logic                    w_up;
   assign w_up = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
   assign w_rf = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_up};
`else
   assign w_rf = {1'b0, w_frac};
`endif
   assign w_fe = w_rf[MAN_W] ? r_re + X_ONE : r_re;

   logic [W-1:0]            w_res;
   logic                    w_ov, w_zf, w_isgn;
   assign w_isgn = r_mul ? (r_sa ^ r_sb) : (r_ia ? r_sa : r_sb);
   always_comb begin
      w_res = '0;
      w_ov  = 1'b0;
      w_zf  = 1'b0;
      if (r_ia | r_ib) begin
         if (r_mul ? (r_za | r_zb) : (r_ia & r_ib & (r_sa != r_sb))) begin
            w_zf = 1'b1;
         end else begin
            w_ov  = 1'b1;
            w_res = {w_isgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
      end else if (r_za | r_zb) begin
         if (r_mul | (r_za & r_zb)) w_zf = 1'b1;
         else if (r_za) w_res = {r_sb, r_eb, r_fb};
         else w_res = {r_sa, r_ea, r_fa};
      end else if (!r_nm[GW-1]) begin
         w_zf = 1'b1;
      end else if (w_fe >= X_EMAX) begin
         w_ov  = 1'b1;
         w_res = {r_rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_fe <= X_ZERO) begin
         w_zf = 1'b1;
      end else begin
         w_res = {r_rs, w_fe[EXP_W-1:0], w_rf[MAN_W-1:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mul   <= 1'b0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_ea    <= '0;
         r_eb    <= '0;
         r_fa    <= '0;
         r_fb    <= '0;
         r_ma    <= '0;
         r_mb    <= '0;
         r_za    <= 1'b0;
         r_zb    <= 1'b0;
         r_ia    <= 1'b0;
         r_ib    <= 1'b0;
         r_big_m <= '0;
         r_sml_m <= '0;
         r_sub   <= 1'b0;
         r_rs    <= 1'b0;
         r_re    <= '0;
         r_sum   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_nm    <= '0;
         r_res   <= '0;
         r_ov    <= 1'b0;
         r_zf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mul   <= (op == 2'b10);
                  r_sa    <= a[W-1];
                  r_sb    <= b[W-1] ^ (op == 2'b01);
                  r_ea    <= w_ea;
                  r_eb    <= w_eb;
                  r_fa    <= a[MAN_W-1:0];
                  r_fb    <= b[MAN_W-1:0];
                  r_ma    <= w_za ? '0 : {1'b1, a[MAN_W-1:0]};
                  r_mb    <= w_zb ? '0 : {1'b1, b[MAN_W-1:0]};
                  r_za    <= w_za;
                  r_zb    <= w_zb;
                  r_ia    <= &w_ea;
                  r_ib    <= &w_eb;
                  r_rs    <= a[W-1] ^ b[W-1];
                  r_re    <= XW'(w_ea) + XW'(w_eb) - X_BIAS;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= (op == 2'b10) ? S_MULT : S_ALIGN;
               end
            end
            S_ALIGN: begin
               r_big_m <= {w_bm, 3'b000};
               r_sml_m <= w_sml_x;
               r_sub   <= r_sa ^ r_sb;
               r_rs    <= w_a_big ? r_sa : r_sb;
               r_re    <= XW'(w_a_big ? r_ea : r_eb);
               r_state <= S_ADDSUB;
            end
            S_ADDSUB: begin
               r_sum   <= r_sub ? {1'b0, r_big_m} - {1'b0, r_sml_m}
                                : {1'b0, r_big_m} + {1'b0, r_sml_m};
               r_state <= S_NORM;
            end
            S_MULT: begin
               r_acc <= w_acc;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(MAN_W)) begin
                  r_sum   <= w_pk;
                  r_state <= S_NORM;
               end
            end
            S_NORM: begin
               if (r_sum[SW-1]) begin
                  r_nm <= {r_sum[SW-1:2], r_sum[1] | r_sum[0]};
                  r_re <= r_re + X_ONE;
               end else begin
                  r_nm <= r_sum[GW-1:0] << w_lsh;
                  r_re <= r_re - XW'(w_lsh);
               end
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_res   <= w_res;
               r_ov    <= w_ov;
               r_zf    <= w_zf;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_res;
   assign overflow  = r_ov;
   assign zero      = r_zf;

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed scoreboard bench for fp_alu_seq at default widths.
// Honours FP_ALU_RNE_EN for the rounding-sensitive expectation.

module tb_fp_alu_seq;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        zero;

   typedef struct {
      string       tag;
      logic [31:0] res;
      logic        ov;
      logic        z;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   fp_alu_seq dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic eov,
                         input logic ez, input int elat, input int hold);
      exp_t e;
      int   lat;
      bit   rdy_seen;
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      e.tag = tag;
      e.res = er;
      e.ov  = eov;
      e.z   = ez;
      e.lat = elat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(3));
      lat = 0;
      rdy_seen = 1'b0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready === 1'b1) rdy_seen = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      e = sb.pop_front();
      chk({e.tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({e.tag, ".result"}, result, e.res);
      chk({e.tag, ".overflow"}, 32'(overflow), 32'(e.ov));
      chk({e.tag, ".zero"}, 32'(zero), 32'(e.z));
      chk({e.tag, ".latency"}, 32'(lat), 32'(e.lat));
      chk({e.tag, ".busy_ready"}, 32'(rdy_seen), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({e.tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         chk({e.tag, ".hold_result"}, result, e.res);
         chk({e.tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({e.tag, ".release_ready"}, 32'(in_ready), 32'd1);
      chk({e.tag, ".release_valid"}, 32'(out_valid), 32'd0);
   endtask

   logic [31:0] rne_exp;

   initial begin
`ifdef FP_ALU_RNE_EN
      rne_exp = 32'h3F800002;
`else
      rne_exp = 32'h3F800001;
`endif
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = OP_ADD;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.result", result, 32'd0);
      chk("reset.overflow", 32'(overflow), 32'd0);
      chk("reset.zero", 32'(zero), 32'd0);
      rst = 1'b0;

      run_op("add_1p1", OP_ADD, 32'h3F800000, 32'h3F800000,
             32'h40000000, 1'b0, 1'b0, 4, 0);
      run_op("mul_1p5x2", OP_MUL, 32'h3FC00000, 32'h40000000,
             32'h40400000, 1'b0, 1'b0, 26, 0);
      run_op("sub_pi_pi", OP_SUB, 32'h40490FDB, 32'h40490FDB,
             32'h00000000, 1'b0, 1'b1, 4, 0);
      run_op("mul_ovf", OP_MUL, 32'h7F7FFFFF, 32'h40000000,
             32'h7F800000, 1'b1, 1'b0, 26, 0);
      run_op("add_round", OP_ADD, 32'h3F800001, 32'h33800000,
             rne_exp, 1'b0, 1'b0, 4, 0);
      run_op("add_hold", OP_ADD, 32'h40400000, 32'h3F000000,
             32'h40600000, 1'b0, 1'b0, 4, 10);
      run_op("sub_neg", OP_SUB, 32'h3F800000, 32'h40000000,
             32'hBF800000, 1'b0, 1'b0, 4, 0);
      run_op("sub_cancel", OP_SUB, 32'h3FC00000, 32'h3FA00000,
             32'h3E800000, 1'b0, 1'b0, 4, 0);
      run_op("mul_neg", OP_MUL, 32'hBFC00000, 32'h40000000,
             32'hC0400000, 1'b0, 1'b0, 26, 0);
      run_op("mul_carry", OP_MUL, 32'h40400000, 32'h40400000,
             32'h41100000, 1'b0, 1'b0, 26, 0);
      run_op("mul_uflow", OP_MUL, 32'h00800000, 32'h00800000,
             32'h00000000, 1'b0, 1'b1, 26, 0);
      run_op("add_zero_a", OP_ADD, 32'h00000000, 32'h40400000,
             32'h40400000, 1'b0, 1'b0, 4, 0);
      run_op("sub_zero_a", OP_SUB, 32'h00000000, 32'h40400000,
             32'hC0400000, 1'b0, 1'b0, 4, 0);
      run_op("inf_minus_inf", OP_SUB, 32'h7F800000, 32'h7F800000,
             32'h00000000, 1'b0, 1'b1, 4, 0);
      run_op("inf_times_0", OP_MUL, 32'hFF800000, 32'h00000000,
             32'h00000000, 1'b0, 1'b1, 26, 0);
      run_op("inf_plus_1", OP_ADD, 32'hFF800000, 32'h3F800000,
             32'hFF800000, 1'b1, 1'b0, 4, 0);
      run_op("rsv_as_add", OP_RSV, 32'h3F800000, 32'h3F800000,
             32'h40000000, 1'b0, 1'b0, 4, 0);

      @(negedge clk);
      in_valid = 1'b1;
      op = OP_MUL;
      a  = 32'h3FC00000;
      b  = 32'h40000000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort.out_valid", 32'(out_valid), 32'd0);
      chk("abort.in_ready", 32'(in_ready), 32'd1);
      chk("abort.result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort.idle_valid", 32'(out_valid), 32'd0);
      run_op("mul_after_rst", OP_MUL, 32'h40000000, 32'h40000000,
             32'h40800000, 1'b0, 1'b0, 26, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
